// File: rtl/dds_pkg.sv
// Shared definitions for the DDS frequency meter: defaults, FSM states and
// the count-to-frequency-word conversion.
package dds_pkg;

  localparam int DDS_N   = 32;
  localparam int DDS_MID = 128;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GATE = 2'd1,
    ST_DONE = 2'd2
  } meter_state_e;

  // A 2^gate_log2 gate makes count/gate * 2^n a plain left shift.
  function automatic logic [63:0] calc_fword(input logic [63:0] cnt,
                                             input int          n,
                                             input int          gate_log2);
    return cnt << (n - gate_log2);
  endfunction

endpackage

// File: rtl/schmitt_edge_det.sv
// Hysteresis zero-crossing detector around mid-scale; flags LOW->HIGH
// transitions combinationally on the qualifying sample.
module schmitt_edge_det
  import dds_pkg::*;
#(
  parameter int MID  = DDS_MID,
  parameter int HYST = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] sample_in,
  input  logic       sample_valid,
  output logic       rise
);

  localparam logic [7:0] HI_TH = 8'(MID + HYST);
  localparam logic [7:0] LO_TH = 8'(MID - HYST);

  logic hyst_state_r;
  logic hyst_next_s;

  // Threshold comparison and rising-edge qualification
  always_comb begin
    hyst_next_s = hyst_state_r;
    rise        = 1'b0;
    if (sample_valid) begin
      if (!hyst_state_r) begin
        if (sample_in >= HI_TH) begin
          hyst_next_s = 1'b1;
          rise        = 1'b1;
        end else begin
          hyst_next_s = 1'b0;
        end
      end else begin
        if (sample_in < LO_TH) begin
          hyst_next_s = 1'b0;
        end else begin
          hyst_next_s = 1'b1;
        end
      end
    end else begin
      hyst_next_s = hyst_state_r;
    end
  end

  // Detector state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hyst_state_r <= 1'b0;
    end else begin
      hyst_state_r <= hyst_next_s;
    end
  end

endmodule

// File: rtl/dds_freq_meter.sv
// Counts rising crossings over a 2^GATE_LOG2-clock gate and reports the
// result both as a raw count and as a DDS frequency control word.
module dds_freq_meter
  import dds_pkg::*;
#(
  parameter int N         = DDS_N,
  parameter int GATE_LOG2 = 20,
  parameter int MID       = DDS_MID,
  parameter int HYST      = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           sample_in,
  input  logic                 sample_valid,
  input  logic                 enable,
  output logic [GATE_LOG2-1:0] edge_cnt,
  output logic [N-1:0]         fword_out,
  output logic                 meas_valid,
  output logic                 busy
);

  localparam logic [GATE_LOG2-1:0] GATE_LAST = {GATE_LOG2{1'b1}};

  meter_state_e         state_r;
  meter_state_e         state_next_s;
  logic [GATE_LOG2-1:0] gate_ctr_r;
  logic [GATE_LOG2-1:0] run_cnt_r;
  logic [GATE_LOG2-1:0] final_cnt_s;
  logic                 rise_s;

  schmitt_edge_det #(
    .MID  (MID),
    .HYST (HYST)
  ) u_det (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .rise         (rise_s)
  );

  // Includes an edge landing in the current cycle so the last gate cycle counts
  assign final_cnt_s = run_cnt_r + {{(GATE_LOG2-1){1'b0}}, rise_s};

  // Next-state logic; dropping enable during a gate aborts without results
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (enable) state_next_s = ST_GATE;
        else        state_next_s = ST_IDLE;
      end
      ST_GATE: begin
        if (!enable)                       state_next_s = ST_IDLE;
        else if (gate_ctr_r == GATE_LAST)  state_next_s = ST_DONE;
        else                               state_next_s = ST_GATE;
      end
      ST_DONE: begin
        if (enable) state_next_s = ST_GATE;
        else        state_next_s = ST_IDLE;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State, gate counter and running edge counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      gate_ctr_r <= {GATE_LOG2{1'b0}};
      run_cnt_r  <= {GATE_LOG2{1'b0}};
    end else begin
      state_r <= state_next_s;
      case (state_r)
        ST_GATE: begin
          gate_ctr_r <= gate_ctr_r + {{(GATE_LOG2-1){1'b0}}, 1'b1};
          run_cnt_r  <= final_cnt_s;
        end
        default: begin
          gate_ctr_r <= {GATE_LOG2{1'b0}};
          run_cnt_r  <= {GATE_LOG2{1'b0}};
        end
      endcase
    end
  end

  // Result and status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_cnt   <= {GATE_LOG2{1'b0}};
      fword_out  <= {N{1'b0}};
      meas_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      if ((state_r == ST_GATE) && (state_next_s == ST_DONE)) begin
        edge_cnt  <= final_cnt_s;
        fword_out <= N'(calc_fword(64'(final_cnt_s), N, GATE_LOG2));
      end else begin
        edge_cnt  <= edge_cnt;
        fword_out <= fword_out;
      end
      meas_valid <= (state_next_s == ST_DONE);
      busy       <= (state_next_s == ST_GATE);
    end
  end

endmodule

// File: tb/tb_dds_freq_meter.sv
// Scoreboard bench for dds_freq_meter with a 1024-clock gate.
module tb_dds_freq_meter;

  localparam int N  = 32;
  localparam int GL = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [7:0]    sample_in;
  logic          sample_valid;
  logic          enable;
  logic [GL-1:0] edge_cnt;
  logic [N-1:0]  fword_out;
  logic          meas_valid;
  logic          busy;

  dds_freq_meter #(.N(N), .GATE_LOG2(GL), .MID(128), .HYST(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .enable       (enable),
    .edge_cnt     (edge_cnt),
    .fword_out    (fword_out),
    .meas_valid   (meas_valid),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cnt;
    logic [31:0] fw;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   pulses   = 0;
  int   cyc      = 0;
  int   last_pulse_cyc = -100000;
  int   mode     = 0;
  int   ph       = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, wanted %0d", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Stimulus waveform generator
  initial begin
    sample_in    = 8'd0;
    sample_valid = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      ph++;
      case (mode)
        0: begin
          sample_valid = 1'b1;
          sample_in    = ((ph % 64) < 32) ? 8'd0 : 8'd255;
        end
        1: begin
          sample_valid = 1'b1;
          sample_in    = ph[0] ? 8'd132 : 8'd124;
        end
        2: begin
          sample_valid = 1'b1;
          sample_in    = ph[0] ? 8'd136 : 8'd119;
        end
        default: begin
          sample_valid = ph[0];
          if (ph[0]) sample_in = ((ph % 64) < 32) ? 8'd0 : 8'd255;
          else       sample_in = ((ph % 64) < 32) ? 8'd255 : 8'd0;
        end
      endcase
    end
  end

  // Monitor: pop and compare on each result pulse
  always @(negedge clk) begin
    if (rst_n && meas_valid) begin
      exp_t e;
      pulses++;
      if (exp_q.size() == 0) begin
        check("unexpected_meas_valid", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("edge_cnt", edge_cnt, e.cnt);
        check("fword_out", fword_out, e.fw);
      end
      if (cyc - last_pulse_cyc < 1100)
        check("pulse_period", cyc - last_pulse_cyc, 1025);
      last_pulse_cyc = cyc;
    end
  end

  task automatic push_exp(input int cnt, input logic [31:0] fw);
    exp_t e;
    e.cnt = cnt;
    e.fw  = fw;
    exp_q.push_back(e);
  endtask

  task automatic wait_pulses(input int target);
    int t = 0;
    while (pulses < target && t < 3000 * 4) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (pulses < target) check("pulse_timeout", pulses, target);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_edge_cnt"}, edge_cnt, 0);
    check({tag, "_fword"}, fword_out, 0);
    check({tag, "_meas_valid"}, meas_valid, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  task automatic one_gate(input int m, input int cnt, input logic [31:0] fw);
    mode = m;
    idle_cycles(200);
    push_exp(cnt, fw);
    enable = 1'b1;
    wait_pulses(pulses + 1);
    enable = 1'b0;
    idle_cycles(5);
  endtask

  initial begin
    int p;
    int t;
    rst_n  = 1'b0;
    enable = 1'b0;
    #1;
    check_zero_outputs("reset");
    idle_cycles(3);
    rst_n = 1'b1;

    // Back-to-back square-wave gates
    mode = 0;
    idle_cycles(200);
    for (int i = 0; i < 3; i++) push_exp(16, 32'd67108864);
    enable = 1'b1;
    wait_pulses(3);
    enable = 1'b0;
    idle_cycles(5);

    one_gate(1, 0, 32'd0);
    one_gate(2, 512, 32'd2147483648);
    one_gate(3, 16, 32'd67108864);

    // Abort mid-gate
    mode = 0;
    idle_cycles(200);
    p = pulses;
    enable = 1'b1;
    t = 0;
    while (!busy && t < 10) begin
      @(negedge clk);
      t++;
    end
    idle_cycles(499);
    check("busy_in_gate", busy, 1);
    enable = 1'b0;
    @(negedge clk);
    check("busy_after_abort", busy, 0);
    idle_cycles(1200);
    check("abort_no_pulse", pulses, p);
    check("abort_keep_cnt", edge_cnt, 16);
    check("abort_keep_fword", fword_out, 67108864);
    push_exp(16, 32'd67108864);
    enable = 1'b1;
    wait_pulses(p + 1);
    enable = 1'b0;
    idle_cycles(5);

    // Asynchronous reset mid-gate
    mode = 2;
    idle_cycles(200);
    enable = 1'b1;
    idle_cycles(300);
    rst_n = 1'b0;
    #1;
    check_zero_outputs("midgate_reset");
    idle_cycles(3);
    push_exp(512, 32'd2147483648);
    p = pulses;
    rst_n = 1'b1;
    wait_pulses(p + 1);
    enable = 1'b0;
    idle_cycles(10);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dds_freq_meter.md
# dds_freq_meter

Measures the frequency of an incoming 8-bit sampled waveform, e.g. the DDS ROM output looped back or an ADC stream. It returns the result as a DDS frequency control word, so a measured tone can be regenerated by loading the value into the phase accumulator's FWORD. The method is hysteresis zero-crossing detection around mid-scale, with rising edges counted over a power-of-two gate of clocks. The power-of-two gate makes the count-to-FWORD conversion a shift, so no divider is needed.

## Interface
- N, 32: FWORD / accumulator width.
- GATE_LOG2, 20: gate length is 2^GATE_LOG2 clocks. Legal range 2..N.
- MID, 128: mid-scale code of offset-binary samples.
- HYST, 8: hysteresis half-width. Requires MID+HYST ≤ 255 and MID-HYST ≥ 0.
- clk, input, 1: system clock.
- rst_n, input, 1: reset. Asynchronous, active-low.
- sample_in, input, 8: unsigned offset-binary sample.
- sample_valid, input, 1: sample_in is valid this cycle.
- enable, input, 1: level. While high, gates run back-to-back.
- edge_cnt, output, GATE_LOG2: rising crossings counted in the last completed gate.
- fword_out, output, N: edge_cnt << (N-GATE_LOG2), zero-filled.
- meas_valid, output, 1: one-cycle pulse when new results are loaded.
- busy, output, 1: high while state is GATE.

## Operation
- Schmitt detector (hyst_state, reset LOW). It updates only on cycles where sample_valid=1.
  - LOW → HIGH when sample_in ≥ MID+HYST. This transition is a rising edge.
  - HIGH → LOW when sample_in < MID-HYST.
  - All other samples hold the state.
- FSM states: IDLE, GATE, DONE. Reset state is IDLE.
  - IDLE: gate_ctr=0 and run_cnt=0. When enable=1, go to GATE.
  - GATE: gate_ctr increments every clock. run_cnt increments for each rising edge detected in a GATE cycle.
    - When gate_ctr = 2^GATE_LOG2-1, go to DONE. On that same clock edge, edge_cnt ← run_cnt (including any edge in that final cycle) and fword_out is updated to match.
    - enable=0 in any GATE cycle aborts: go to IDLE, results are not updated, and no meas_valid is issued.
  - DONE: meas_valid=1 for this cycle only. Clear gate_ctr and run_cnt. If enable=1 go to GATE, else go to IDLE.
- Edges detected in IDLE or DONE cycles are not counted. The detector state still updates in those cycles.
- The detector keeps running across gates and aborts. It is never cleared except by reset.
- Width rule: Schmitt detection needs at least 2 samples per input period, so run_cnt ≤ 2^(GATE_LOG2-1) and cannot overflow GATE_LOG2 bits. No saturation logic is required.
- Reset values: edge_cnt=0, fword_out=0, meas_valid=0, busy=0.
- Reset asserted mid-gate discards everything. Restart is from IDLE with the detector LOW.

## Timing
- If enable is sampled high in IDLE at edge k, GATE occupies exactly the 2^GATE_LOG2 cycles after k.
- Results are loaded and meas_valid is high in the following cycle (DONE).
- Back-to-back measurement period is 2^GATE_LOG2+1 clocks, because of one DONE dead cycle per gate.
- Rising-edge qualification is combinational from sample_in, hyst_state and sample_valid. It is counted at the same clock edge, giving 0 cycles of added latency.
- edge_cnt and fword_out hold until the next completed gate.

## Structure
- The shared package dds_pkg holds:
  - the N and MID defaults;
  - the FSM state enum (IDLE/GATE/DONE);
  - a function computing fword from the count and GATE_LOG2.
- Sub-module: schmitt_edge_det (sample_in, sample_valid, MID, HYST → rise pulse), registered state only.
- Gate counter, edge counter, FSM and result registers live in the top.

## Test plan
All scenarios use GATE_LOG2=10 (1024-clock gate) and sample_valid=1 unless stated.
- Square wave 0/255 with period 64 clocks, enable held high → every meas_valid shows edge_cnt=16 and fword_out=16<<22=67108864. Pulses are exactly 1025 clocks apart.
- Input toggling 124/132 every clock (never reaching 136) → edge_cnt=0 and fword_out=0. Toggling 119/136 (reaching both thresholds, 119 < MID-HYST=120 and 136 = MID+HYST) → edge_cnt=512.
- Same square wave with sample_valid=1 only every other cycle (the wave is unchanged) → edge_cnt=16. Samples presented while sample_valid=0 have no effect.
- Drop enable at GATE cycle 500 → no meas_valid, busy falls the next cycle, and the previous edge_cnt/fword_out are retained. Re-raising enable starts a full fresh gate.
- Assert rst_n=0 mid-gate → all outputs read 0 immediately (asynchronous) and state is IDLE. After release, the first result matches the stimulus of a full post-reset gate.
- Loopback from the DDS phase accumulator (FWORD=429497, sample the ROM sine) with GATE_LOG2=20 → fword_out is within one LSB step (4096) of 429497, i.e. 425984 or 430080.
